// File: rtl/rs_decode_sched.sv
`default_nettype none
// ============================================================================
// Module      : rs_decode_sched
// Description : Frame-level sequencer for the RS decoder pipeline. Accepts one
//               buffered codeword at a time and walks it through syndrome,
//               key-equation, Chien search and correction stages. Each stage
//               is started with a one-cycle pulse and finished by its done
//               input. Early exit, uncorrectable and timeout outcomes are
//               decided here. Each frame gets a held status, and saturating
//               good/fail frame counters are kept.
// Ports       : clk, rst (async, active-high)
//               frame_valid / frame_ready     - codeword buffer handshake
//               busy                          - not idle
//               syn_/key_/chn_/cor_start,done - stage handshakes
//               syn_zero, key_deg, chn_roots  - stage results, sampled with done
//               out_valid / out_ready         - result handshake
//               out_status                    - 00 clean, 01 corrected,
//                                               10 uncorrectable, 11 timeout
//               ok_count, fail_count          - saturating frame counters
// Revision    : 1.0 - initial release
// ============================================================================
module rs_decode_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             busy,
  output logic             syn_start,
  input  logic             syn_done,
  input  logic             syn_zero,
  output logic             key_start,
  input  logic             key_done,
  input  logic [1:0]       key_deg,
  output logic             chn_start,
  input  logic             chn_done,
  input  logic [1:0]       chn_roots,
  output logic             cor_start,
  input  logic             cor_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_status,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int                 TIMER_W   = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYN  = 3'd1,
    KEY  = 3'd2,
    CHN  = 3'd3,
    COR  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state, state_n;
  logic               entry, entry_n;     // high only in the first cycle of a stage
  logic [TIMER_W-1:0] timer;
  logic [1:0]         status, status_n;
  logic [1:0]         deg, deg_n;         // locator degree kept for the root check
  logic               ok_inc, fail_inc;
  logic               stage_done;
  logic               in_stage, in_stage_n;

  assign in_stage   = (state   inside {SYN, KEY, CHN, COR});
  assign in_stage_n = (state_n inside {SYN, KEY, CHN, COR});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      entry      <= 1'b0;
      timer      <= '0;
      status     <= 2'b00;
      deg        <= 2'd0;
      ok_count   <= '0;
      fail_count <= '0;
    end else begin
      state  <= state_n;
      entry  <= entry_n;
      status <= status_n;
      deg    <= deg_n;
      // Timer counts cycles spent in the current stage; it never passes
      // TIMER_MAX because the stage is left at that value.
      if (entry_n || !in_stage_n) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
      if (ok_inc && (ok_count != CNT_MAX)) begin
        ok_count <= ok_count + CNT_W'(1);
      end
      if (fail_inc && (fail_count != CNT_MAX)) begin
        fail_count <= fail_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n    = state;
    status_n   = status;
    deg_n      = deg;
    ok_inc     = 1'b0;
    fail_inc   = 1'b0;
    stage_done = 1'b0;
    entry_n    = 1'b0;

    // Only the current stage's done counts, and never in its entry cycle.
    case (state)
      SYN:     stage_done = syn_done & ~entry;
      KEY:     stage_done = key_done & ~entry;
      CHN:     stage_done = chn_done & ~entry;
      COR:     stage_done = cor_done & ~entry;
      default: stage_done = 1'b0;
    endcase

    case (state)
      IDLE: begin
        if (frame_valid) state_n = SYN;
      end
      SYN: begin
        if (stage_done) begin
          if (syn_zero) begin
            state_n  = DONE;
            status_n = 2'b00;
          end else begin
            state_n = KEY;
          end
        end
      end
      KEY: begin
        if (stage_done) begin
          deg_n = key_deg;
          if (key_deg == 2'd0) begin
            state_n  = DONE;
            status_n = 2'b10;
          end else begin
            state_n = CHN;
          end
        end
      end
      CHN: begin
        if (stage_done) begin
          if (chn_roots != deg) begin
            state_n  = DONE;
            status_n = 2'b10;
          end else begin
            state_n = COR;
          end
        end
      end
      COR: begin
        if (stage_done) begin
          state_n  = DONE;
          status_n = 2'b01;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n  = IDLE;
          ok_inc   = ~status[1];
          fail_inc = status[1];
        end
      end
      default: state_n = IDLE;
    endcase

    // A done arriving in the timeout cycle takes precedence.
    if (in_stage && !stage_done && (timer == TIMER_MAX)) begin
      state_n  = DONE;
      status_n = 2'b11;
    end

    entry_n = (state_n != state) && in_stage_n;
  end

  assign frame_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign syn_start   = entry && (state == SYN);
  assign key_start   = entry && (state == KEY);
  assign chn_start   = entry && (state == CHN);
  assign cor_start   = entry && (state == COR);
  assign out_valid   = (state == DONE);
  assign out_status  = status;

endmodule
`default_nettype wire

// File: tb/tb_rs_decode_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_decode_sched
// Description : Self-checking bench for rs_decode_sched (TIMEOUT=8, CNT_W=2).
//               Stage units are emulated by a responder that answers each
//               start pulse after a chosen delay. Expected status and latency
//               come from a small reference model and are queued at launch,
//               then popped when the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_decode_sched;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             frame_valid, frame_ready, busy;
  logic             syn_start, syn_done, syn_zero;
  logic             key_start, key_done;
  logic [1:0]       key_deg;
  logic             chn_start, chn_done;
  logic [1:0]       chn_roots;
  logic             cor_start, cor_done;
  logic             out_valid, out_ready;
  logic [1:0]       out_status;
  logic [CNT_W-1:0] ok_count, fail_count;

  rs_decode_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .key_start(key_start), .key_done(key_done), .key_deg(key_deg),
    .chn_start(chn_start), .chn_done(chn_done), .chn_roots(chn_roots),
    .cor_start(cor_start), .cor_done(cor_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .ok_count(ok_count), .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [1:0] sb_q[$];
  int         lat_q[$];
  int         model_ok   = 0;
  int         model_fail = 0;
  int         obs_lat;
  int         obs_seq;
  int         obs_starts[4];

  task automatic clear_inputs;
    frame_valid = 0; syn_done = 0; syn_zero = 0; key_done = 0; key_deg = 0;
    chn_done = 0; chn_roots = 0; cor_done = 0; out_ready = 0;
  endtask

  // Launch one frame and play the stage units. hang = stage (1..4) whose done
  // is withheld, 0 for none. Returns at the negedge where out_valid is seen.
  task automatic run_frame(input logic z, input logic [1:0] kd, input logic [1:0] rt,
                           input int hang, input int key_delay);
    logic [1:0] exp_st;
    int exp_lat, pend, pend_k, delay;
    exp_lat = 1;
    if (hang == 1) begin exp_st = 2'b11; exp_lat += TIMEOUT + 1; end
    else begin
      exp_lat += 2;
      if (z) exp_st = 2'b00;
      else if (hang == 2 || key_delay > TIMEOUT) begin exp_st = 2'b11; exp_lat += TIMEOUT + 1; end
      else begin
        exp_lat += key_delay + 1;
        if (kd == 0) exp_st = 2'b10;
        else if (hang == 3) begin exp_st = 2'b11; exp_lat += TIMEOUT + 1; end
        else begin
          exp_lat += 2;
          if (rt != kd) exp_st = 2'b10;
          else if (hang == 4) begin exp_st = 2'b11; exp_lat += TIMEOUT + 1; end
          else begin exp_st = 2'b01; exp_lat += 2; end
        end
      end
    end
    sb_q.push_back(exp_st);
    lat_q.push_back(exp_lat);

    obs_lat = -1; obs_seq = 0; obs_starts = '{default: 0};
    pend = 0; pend_k = 0;
    @(negedge clk);
    frame_valid = 1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      frame_valid = 0; syn_done = 0; key_done = 0; chn_done = 0; cor_done = 0;
      if (out_valid) begin obs_lat = k; break; end
      if (syn_start) begin obs_starts[0]++; obs_seq = obs_seq * 10 + 1; pend = 1; pend_k = k; end
      if (key_start) begin obs_starts[1]++; obs_seq = obs_seq * 10 + 2; pend = 2; pend_k = k; end
      if (chn_start) begin obs_starts[2]++; obs_seq = obs_seq * 10 + 3; pend = 3; pend_k = k; end
      if (cor_start) begin obs_starts[3]++; obs_seq = obs_seq * 10 + 4; pend = 4; pend_k = k; end
      if (pend != 0 && pend != hang) begin
        delay = (pend == 2) ? key_delay : 1;
        if (k == pend_k + delay) begin
          case (pend)
            1: begin syn_done = 1; syn_zero = z; end
            2: begin key_done = 1; key_deg = kd; end
            3: begin chn_done = 1; chn_roots = rt; end
            default: cor_done = 1;
          endcase
        end
      end
    end
  endtask

  // Result handshake; model counters follow the expected status.
  task automatic finish_frame(input logic [1:0] exp_st);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    if (exp_st[1]) begin if (model_fail < CMAX) model_fail++; end
    else begin if (model_ok < CMAX) model_ok++; end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({frame_ready, busy, out_valid, out_status, syn_start, key_start, chn_start, cor_start} !== 9'b1_0_0_00_0000)
      $display("FAIL reset_during: ctl=%b required 100000000", {frame_ready, busy, out_valid, out_status, syn_start, key_start, chn_start, cor_start});
    else pass_cnt++;
    rst = 0;
    @(negedge clk);
    total_cnt++;
    if ({frame_ready, busy, out_valid, out_status, ok_count, fail_count} !== {5'b1_0_0_00, {2*CNT_W{1'b0}}})
      $display("FAIL reset_after: ready=%b busy=%b ov=%b st=%b ok=%0d fail=%0d", frame_ready, busy, out_valid, out_status, ok_count, fail_count);
    else pass_cnt++;
  endtask

  task automatic test_clean;
    logic [1:0] e; int el;
    run_frame(1'b1, 2'd0, 2'd0, 0, 1);
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (obs_lat !== el) $display("FAIL clean_latency: got %0d need %0d", obs_lat, el); else pass_cnt++;
    total_cnt++; if (out_status !== e) $display("FAIL clean_status: got %b need %b", out_status, e); else pass_cnt++;
    total_cnt++; if (obs_seq !== 1) $display("FAIL clean_starts: seq %0d need 1", obs_seq); else pass_cnt++;
    finish_frame(e);
    total_cnt++;
    if (ok_count !== CNT_W'(model_ok) || frame_ready !== 1'b1)
      $display("FAIL clean_count: ok=%0d need %0d ready=%b", ok_count, model_ok, frame_ready);
    else pass_cnt++;
  endtask

  task automatic test_corrected;
    logic [1:0] e; int el;
    run_frame(1'b0, 2'd2, 2'd2, 0, 1);
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (obs_lat !== el) $display("FAIL corr_latency: got %0d need %0d", obs_lat, el); else pass_cnt++;
    total_cnt++; if (out_status !== e) $display("FAIL corr_status: got %b need %b", out_status, e); else pass_cnt++;
    total_cnt++;
    if (obs_seq !== 1234 || obs_starts[0] !== 1 || obs_starts[1] !== 1 || obs_starts[2] !== 1 || obs_starts[3] !== 1)
      $display("FAIL corr_starts: seq %0d need 1234 (single pulses)", obs_seq);
    else pass_cnt++;
    finish_frame(e);
    total_cnt++; if (ok_count !== CNT_W'(model_ok)) $display("FAIL corr_count: ok=%0d need %0d", ok_count, model_ok); else pass_cnt++;
  endtask

  task automatic test_uncorrectable;
    logic [1:0] e; int el;
    run_frame(1'b0, 2'd3, 2'd1, 0, 1);
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (out_status !== e || obs_lat !== el) $display("FAIL mismatch_status: got %b/%0d need %b/%0d", out_status, obs_lat, e, el); else pass_cnt++;
    total_cnt++; if (obs_seq !== 123) $display("FAIL mismatch_starts: seq %0d need 123", obs_seq); else pass_cnt++;
    finish_frame(e);
    total_cnt++; if (fail_count !== CNT_W'(model_fail)) $display("FAIL mismatch_count: fail=%0d need %0d", fail_count, model_fail); else pass_cnt++;
    run_frame(1'b0, 2'd0, 2'd0, 0, 1);
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (out_status !== e || obs_lat !== el) $display("FAIL deg0_status: got %b/%0d need %b/%0d", out_status, obs_lat, e, el); else pass_cnt++;
    total_cnt++; if (obs_seq !== 12) $display("FAIL deg0_starts: seq %0d need 12", obs_seq); else pass_cnt++;
    finish_frame(e);
    total_cnt++; if (fail_count !== CNT_W'(model_fail)) $display("FAIL deg0_count: fail=%0d need %0d", fail_count, model_fail); else pass_cnt++;
  endtask

  task automatic test_timeout;
    logic [1:0] e; int el;
    run_frame(1'b0, 2'd2, 2'd2, 3, 1);   // Chien never answers
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (out_status !== e || obs_lat !== el) $display("FAIL chn_timeout: got %b/%0d need %b/%0d", out_status, obs_lat, e, el); else pass_cnt++;
    finish_frame(e);
    run_frame(1'b0, 2'd2, 2'd2, 0, TIMEOUT);   // key_done exactly at timer==TIMEOUT
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (out_status !== e || obs_lat !== el) $display("FAIL key_at_limit: got %b/%0d need %b/%0d", out_status, obs_lat, e, el); else pass_cnt++;
    total_cnt++; if (obs_seq !== 1234) $display("FAIL key_at_limit_starts: seq %0d need 1234", obs_seq); else pass_cnt++;
    finish_frame(e);
    run_frame(1'b0, 2'd2, 2'd2, 0, TIMEOUT + 1);   // one cycle too late
    e = sb_q.pop_front(); el = lat_q.pop_front();
    total_cnt++; if (out_status !== e || obs_lat !== el) $display("FAIL key_timeout: got %b/%0d need %b/%0d", out_status, obs_lat, e, el); else pass_cnt++;
    finish_frame(e);
    total_cnt++;
    if (ok_count !== CNT_W'(model_ok) || fail_count !== CNT_W'(model_fail))
      $display("FAIL timeout_counts: ok=%0d fail=%0d need %0d %0d", ok_count, fail_count, model_ok, model_fail);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [1:0] e; int el; int bad;
    run_frame(1'b0, 2'd1, 2'd1, 0, 1);
    e = sb_q.pop_front(); el = lat_q.pop_front();
    bad = 0;
    frame_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_status !== e || syn_start !== 1'b0 || busy !== 1'b1) bad++;
    end
    frame_valid = 0;
    total_cnt++; if (bad !== 0) $display("FAIL hold_stable: %0d bad cycles need 0 (status %b need %b)", bad, out_status, e); else pass_cnt++;
    finish_frame(e);
    total_cnt++; if (frame_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold_release: ready=%b ov=%b need 1 0", frame_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_saturation;
    logic [1:0] e; int el; int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b1, 2'd0, 2'd0, 0, 1);
      e = sb_q.pop_front(); el = lat_q.pop_front();
      if (out_status !== e || obs_lat !== el) bad++;
      finish_frame(e);
    end
    total_cnt++; if (bad !== 0) $display("FAIL sat_frames: %0d bad frames need 0", bad); else pass_cnt++;
    total_cnt++; if (ok_count !== CNT_W'(model_ok)) $display("FAIL sat_ok: ok=%0d need %0d", ok_count, model_ok); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    @(negedge clk); frame_valid = 1;
    @(negedge clk); frame_valid = 0;
    @(negedge clk); syn_done = 1; syn_zero = 0;
    @(negedge clk); syn_done = 0;
    total_cnt++; if (key_start !== 1'b1) $display("FAIL mid_key_entry: key_start=%b need 1", key_start); else pass_cnt++;
    rst = 1;
    @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1 || busy !== 1'b0 || ok_count !== '0 || fail_count !== '0 || out_valid !== 1'b0)
      $display("FAIL mid_reset: ready=%b busy=%b ok=%0d fail=%0d ov=%b", frame_ready, busy, ok_count, fail_count, out_valid);
    else pass_cnt++;
    rst = 0; model_ok = 0; model_fail = 0;
    key_done = 1; key_deg = 2;
    @(negedge clk); key_done = 0;
    @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1 || chn_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL late_key_done: ready=%b chn_start=%b busy=%b need 1 0 0", frame_ready, chn_start, busy);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_clean();
    test_corrected();
    test_uncorrectable();
    test_timeout();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_decode_sched.md
# rs_decode_sched

Frame-level sequencer for the RS decoder pipeline: it accepts one buffered codeword at a time and runs the four stages in order with start/done handshakes. The stages are syndrome calculation, key-equation solve (the error-locator block driven by its load strobe and `ready`), Chien search and correction. It decides early exit, uncorrectable and timeout outcomes, presents a per-frame status, and keeps saturating good/fail frame counters. One instance sits between the codeword buffer and the decoder stage blocks.

## Interface
- `TIMEOUT`, 64: max cycles a stage may take before the frame is abandoned (≥2).
- `CNT_W`, 16: width of frame counters.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `frame_valid`  in  1  codeword ready in buffer.
- `frame_ready`  out  1  scheduler can accept a frame; equals (state==IDLE).
- `busy`  out  1  high in any state except IDLE.
- `syn_start`  out  1  one-cycle pulse to syndrome unit.
- `syn_done`  in  1  syndromes valid.
- `syn_zero`  in  1  all six syndromes zero; sampled with `syn_done`.
- `key_start`  out  1  one-cycle pulse to error-locator block.
- `key_done`  in  1  locator coefficients valid.
- `key_deg`  in  2  locator degree 0..3; sampled with `key_done`.
- `chn_start`  out  1  one-cycle pulse to Chien search.
- `chn_done`  in  1  search complete.
- `chn_roots`  in  2  roots found 0..3; sampled with `chn_done`.
- `cor_start`  out  1  one-cycle pulse to correction unit.
- `cor_done`  in  1  corrected codeword written back.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes result.
- `out_status`  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 timeout; valid while `out_valid`.
- `ok_count`  out  CNT_W  frames delivered with status 00/01.
- `fail_count`  out  CNT_W  frames delivered with status 10/11.

## Operation
- States: IDLE, SYN, KEY, CHN, COR, DONE.
- IDLE: `frame_valid` && `frame_ready` moves to SYN.
- Stage entry: the `*_start` output for the new stage pulses high in the entry cycle only. The stage timer clears to 0 on entry and increments each cycle in the stage.
- The stage's done input is sampled only from the cycle after entry onward. Done inputs of non-current stages are ignored.
- SYN done: `syn_zero`=1 goes to DONE with status 00; otherwise goes to KEY.
- KEY done: `key_deg`=0 goes to DONE with status 10 (nonzero syndromes, no locator); otherwise goes to CHN.
- CHN done: `chn_roots`≠`key_deg` goes to DONE with status 10; otherwise goes to COR. `key_deg` is captured on `key_done`.
- COR done goes to DONE with status 01.
- Timeout: in any stage, if the timer equals TIMEOUT and done is low that cycle, go to DONE with status 11. Done and timer==TIMEOUT in the same cycle means done wins.
- DONE: `out_valid`=1 and `out_status` is held stable until `out_ready`. On the handshake cycle, return to IDLE and increment `ok_count` (00/01) or `fail_count` (10/11).
- Counters saturate at all-ones and never wrap.
- `out_ready` outside DONE has no effect. `frame_valid` outside IDLE is ignored; the buffer holds it.

## Timing
- Reset values: state IDLE, all `*_start`=0, `out_valid`=0, `out_status`=00, both counters 0, `busy`=0, `frame_ready`=1. These hold during and immediately after reset.
- Reset mid-frame aborts immediately. No start pulse, no status and no counter update occur for the aborted frame.
- Accept at cycle t: SYN entered and `syn_start`=1 at t+1. Earliest `syn_done` is at t+2.
- Earliest stage advance: done at entry+1 gives the next stage's entry at entry+2.
- Minimum clean-frame latency: accept t, `out_valid` at t+3.
- Minimum corrected-frame latency: accept t, `out_valid` at t+9.
- Timeout: a stage entered at e with no done reaches DONE at e+TIMEOUT+1.
- Back-to-back frames: the handshake at cycle d returns to IDLE at d+1. The next accept is no earlier than d+1.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.

## Test plan
- Clean frame: accept at t, `syn_done`+`syn_zero` at t+2 -> `out_valid` at t+3, status 00, `ok_count`=1, no `key_start` seen.
- Two-error frame: `syn_zero`=0, `key_deg`=2, `chn_roots`=2, `cor_done` each one cycle after its start -> single pulses on each start output in order, status 01 at t+9.
- Locator mismatch: `key_deg`=3, `chn_roots`=1 -> status 10, no `cor_start`, `fail_count`=1. Repeat with `key_deg`=0 -> status 10 directly from KEY.
- Timeout: TIMEOUT=8, withhold `chn_done` -> DONE at CHN entry+9, status 11. Separately, raise `key_done` exactly at timer=8 -> proceeds to CHN, not timeout.
- Backpressure/saturation: CNT_W=2, hold `out_ready` low 20 cycles -> `out_valid`/`out_status` stable, `frame_valid` ignored. Deliver 5 clean frames -> `ok_count`=3, no wrap.
- Reset mid-operation: assert `rst` in KEY for 1 cycle -> immediate IDLE, `frame_ready`=1, counters 0. A late `key_done` after reset causes no transition.
